// File: rtl/game_link_pkg.sv
// Shared definitions for the inter-board game-state link (transmitter and uart_demux).
// GAME_TX_CHECKSUM_EN adds a sixth, XOR-checksum word to every frame.
package game_link_pkg;

  localparam int WORD_W    = 16;
  localparam int PAYLOAD_W = 12;
  localparam int TAG_W     = 4;
  localparam int IDX_W     = 3;

  localparam logic [TAG_W-1:0] TAG_PL1_X  = 4'd0;
  localparam logic [TAG_W-1:0] TAG_PL1_Y  = 4'd1;
  localparam logic [TAG_W-1:0] TAG_BALL_X = 4'd2;
  localparam logic [TAG_W-1:0] TAG_BALL_Y = 4'd3;
  localparam logic [TAG_W-1:0] TAG_STATUS = 4'd4;
  localparam logic [TAG_W-1:0] TAG_CSUM   = 4'd5;

`ifdef GAME_TX_CHECKSUM_EN
  localparam int WORDS_PER_FRAME = 6;
`else
  localparam int WORDS_PER_FRAME = 5;
`endif

  // XOR over the five data payloads; the receiver recomputes the same value.
  function automatic logic [PAYLOAD_W-1:0] payload_csum(
    input logic [PAYLOAD_W-1:0] p0,
    input logic [PAYLOAD_W-1:0] p1,
    input logic [PAYLOAD_W-1:0] p2,
    input logic [PAYLOAD_W-1:0] p3,
    input logic [PAYLOAD_W-1:0] p4
  );
    return p0 ^ p1 ^ p2 ^ p3 ^ p4;
  endfunction

endpackage

// File: rtl/game_state_snapshot.sv
// Frame snapshot register bank and word-index to tagged-word multiplexer.
// GAME_TX_CHECKSUM_EN enables the checksum word at index 5.
module game_state_snapshot
  import game_link_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [11:0]          pl1_posx,
  input  logic [11:0]          pl1_posy,
  input  logic [11:0]          ball_posx,
  input  logic [11:0]          ball_posy,
  input  logic [3:0]           pl1_score,
  input  logic [3:0]           pl2_score,
  input  logic                 flag_point,
  input  logic                 end_game,
  input  logic [IDX_W-1:0]     idx,
  output logic [WORD_W-1:0]    word
);

  logic [PAYLOAD_W-1:0] pl1_x_r;
  logic [PAYLOAD_W-1:0] pl1_y_r;
  logic [PAYLOAD_W-1:0] ball_x_r;
  logic [PAYLOAD_W-1:0] ball_y_r;
  logic [PAYLOAD_W-1:0] status_r;
  logic [WORD_W-1:0]    word_s;
`ifdef GAME_TX_CHECKSUM_EN
  logic [PAYLOAD_W-1:0] csum_s;
`endif

  // Capture every game input once per frame so mid-frame changes cannot tear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pl1_x_r  <= 12'd0;
      pl1_y_r  <= 12'd0;
      ball_x_r <= 12'd0;
      ball_y_r <= 12'd0;
      status_r <= 12'd0;
    end else if (load) begin
      pl1_x_r  <= pl1_posx;
      pl1_y_r  <= pl1_posy;
      ball_x_r <= ball_posx;
      ball_y_r <= ball_posy;
      status_r <= {pl1_score, pl2_score, flag_point, end_game, 2'b00};
    end else begin
      pl1_x_r  <= pl1_x_r;
      pl1_y_r  <= pl1_y_r;
      ball_x_r <= ball_x_r;
      ball_y_r <= ball_y_r;
      status_r <= status_r;
    end
  end

`ifdef GAME_TX_CHECKSUM_EN
  assign csum_s = payload_csum(pl1_x_r, pl1_y_r, ball_x_r, ball_y_r, status_r);
`endif

  // Select the tagged word for the current frame position.
  always_comb begin
    word_s = 16'h0000;
    case (idx)
      3'd0:    word_s = {TAG_PL1_X,  pl1_x_r};
      3'd1:    word_s = {TAG_PL1_Y,  pl1_y_r};
      3'd2:    word_s = {TAG_BALL_X, ball_x_r};
      3'd3:    word_s = {TAG_BALL_Y, ball_y_r};
      3'd4:    word_s = {TAG_STATUS, status_r};
`ifdef GAME_TX_CHECKSUM_EN
      3'd5:    word_s = {TAG_CSUM,   csum_s};
`endif
      default: word_s = 16'h0000;
    endcase
  end

  assign word = word_s;

endmodule

// File: rtl/game_state_tx.sv
// Game-state link transmitter: snapshots game state on frame_tick and sends it
// as tagged 16-bit words, one per UART handshake. Option: GAME_TX_CHECKSUM_EN.
module game_state_tx
  import game_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int TO_W           = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [11:0] pl1_posx,
  input  logic [11:0] pl1_posy,
  input  logic [11:0] ball_posx,
  input  logic [11:0] ball_posy,
  input  logic [3:0]  pl1_score,
  input  logic [3:0]  pl2_score,
  input  logic        flag_point,
  input  logic        end_game,
  input  logic        conv16to8ready,
  input  logic        tx_done,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        busy,
  output logic        frame_sent,
  output logic        tx_error
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_SEND      = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              pending_r;
  logic [IDX_W-1:0]  idx_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic [WORD_W-1:0] data_r;
  logic              data_valid_r;
  logic              busy_r;
  logic              frame_sent_r;
  logic              tx_error_r;
  logic [WORD_W-1:0] snap_word_s;
  logic              issue_s;
  logic              done_s;
  logic              last_s;
  logic              timeout_s;

  game_state_snapshot u_snapshot (
    .clk        (clk),
    .rst        (rst),
    .load       (state_r == ST_LOAD),
    .pl1_posx   (pl1_posx),
    .pl1_posy   (pl1_posy),
    .ball_posx  (ball_posx),
    .ball_posy  (ball_posy),
    .pl1_score  (pl1_score),
    .pl2_score  (pl2_score),
    .flag_point (flag_point),
    .end_game   (end_game),
    .idx        (idx_r),
    .word       (snap_word_s)
  );

  assign issue_s   = (state_r == ST_SEND) && conv16to8ready;
  assign done_s    = (state_r == ST_WAIT_DONE) && tx_done;
  assign last_s    = (idx_r == LAST_IDX);
  assign timeout_s = (state_r == ST_WAIT_DONE) && !tx_done && (to_cnt_r == TO_LIMIT);

  // Next-state decode; a tx_done in the same cycle as the timeout wins.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_tick || pending_r) state_nxt_s = ST_LOAD;
        else                         state_nxt_s = ST_IDLE;
      end
      ST_LOAD: state_nxt_s = ST_SEND;
      ST_SEND: begin
        if (conv16to8ready) state_nxt_s = ST_WAIT_DONE;
        else                state_nxt_s = ST_SEND;
      end
      ST_WAIT_DONE: begin
        if (done_s)         state_nxt_s = last_s ? ST_IDLE : ST_SEND;
        else if (timeout_s) state_nxt_s = ST_IDLE;
        else                state_nxt_s = ST_WAIT_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register; busy is registered from the next state so it tracks state_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // One-deep tick memory: set by any tick while busy, consumed on leaving IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= 1'b0;
    end else if (state_r != ST_IDLE) begin
      if (frame_tick) pending_r <= 1'b1;
    end else begin
      pending_r <= 1'b0;
    end
  end

  // Word index within the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= {IDX_W{1'b0}};
    end else if (state_r == ST_LOAD) begin
      idx_r <= {IDX_W{1'b0}};
    end else if (done_s && !last_s) begin
      idx_r <= idx_r + IDX_W'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  // Cycles spent waiting for tx_done on the current word; saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (issue_s) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if ((state_r == ST_WAIT_DONE) && (to_cnt_r != TO_LIMIT)) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Word issue; data holds its value until the next strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r       <= 16'h0000;
      data_valid_r <= 1'b0;
    end else if (issue_s) begin
      data_r       <= snap_word_s;
      data_valid_r <= 1'b1;
    end else begin
      data_r       <= data_r;
      data_valid_r <= 1'b0;
    end
  end

  // Frame completion pulse and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_sent_r <= 1'b0;
      tx_error_r   <= 1'b0;
    end else begin
      frame_sent_r <= done_s && last_s;
      tx_error_r   <= tx_error_r | timeout_s;
    end
  end

  assign data       = data_r;
  assign data_valid = data_valid_r;
  assign busy       = busy_r;
  assign frame_sent = frame_sent_r;
  assign tx_error   = tx_error_r;

endmodule

// File: tb/tb_game_state_tx.sv
// Directed bench for game_state_tx; expectations follow GAME_TX_CHECKSUM_EN when defined.
module tb_game_state_tx;

  localparam int TO  = 300;
  localparam int GAP = 100;
`ifdef GAME_TX_CHECKSUM_EN
  localparam int NW = 6;
`else
  localparam int NW = 5;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic [11:0] pl1_posx, pl1_posy, ball_posx, ball_posy;
  logic [3:0]  pl1_score, pl2_score;
  logic        flag_point, end_game;
  logic        conv16to8ready;
  logic        tx_done;
  logic [15:0] data;
  logic        data_valid, busy, frame_sent, tx_error;

  int total = 0;
  int bad   = 0;
  int dv_cnt = 0;
  int fs_cnt = 0;
  logic [15:0] exp_w [0:5];

  game_state_tx #(.TIMEOUT_CYCLES(TO), .TO_W(9)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .pl1_posx       (pl1_posx),
    .pl1_posy       (pl1_posy),
    .ball_posx      (ball_posx),
    .ball_posy      (ball_posy),
    .pl1_score      (pl1_score),
    .pl2_score      (pl2_score),
    .flag_point     (flag_point),
    .end_game       (end_game),
    .conv16to8ready (conv16to8ready),
    .tx_done        (tx_done),
    .data           (data),
    .data_valid     (data_valid),
    .busy           (busy),
    .frame_sent     (frame_sent),
    .tx_error       (tx_error)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge.
  always @(negedge clk) begin
    if (data_valid === 1'b1) dv_cnt = dv_cnt + 1;
    if (frame_sent === 1'b1) fs_cnt = fs_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic wait_dv(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (data_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Answer each word with tx_done GAP cycles after its strobe and check the words.
  task automatic serve_frame(input bit extra_ticks);
    int   dv0, fs0;
    logic ok;
    dv0 = dv_cnt;
    fs0 = fs_cnt;
    for (int k = 0; k < NW; k++) begin
      wait_dv(ok);
      chk("dv_seen", {31'd0, ok}, 32'd1);
      chk("word", {16'd0, data}, {16'd0, exp_w[k]});
      if (extra_ticks && k == 2) begin
        tick();
        step();
        tick();
        step();
        repeat (GAP - 5) step();
      end else begin
        repeat (GAP - 1) step();
      end
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      if (k == NW - 1) begin
        chk("frame_sent_last", {31'd0, frame_sent}, 32'd1);
        chk("busy_after_last", {31'd0, busy}, 32'd0);
      end else begin
        chk("frame_sent_mid", {31'd0, frame_sent}, 32'd0);
      end
    end
    step();
    chk("dv_count", dv_cnt - dv0, NW);
    chk("fs_count", fs_cnt - fs0, 32'd1);
  endtask

  initial begin
    logic ok;
    int   dv0, fs0;

    rst = 1'b1;
    frame_tick = 1'b0;
    pl1_posx = 12'd0; pl1_posy = 12'd0; ball_posx = 12'd0; ball_posy = 12'd0;
    pl1_score = 4'd0; pl2_score = 4'd0; flag_point = 1'b0; end_game = 1'b0;
    conv16to8ready = 1'b0;
    tx_done = 1'b0;
    repeat (3) step();
    chk("rst_data", {16'd0, data}, 32'd0);
    chk("rst_dv", {31'd0, data_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fs", {31'd0, frame_sent}, 32'd0);
    chk("rst_err", {31'd0, tx_error}, 32'd0);
    rst = 1'b0;
    step();

    // Basic frame; pl1_posx changes right after LOAD and must not leak in.
    pl1_posx = 12'd300; pl1_posy = 12'd500; ball_posx = 12'd512; ball_posy = 12'd100;
    pl1_score = 4'd3; pl2_score = 4'd7; flag_point = 1'b1; end_game = 1'b0;
    conv16to8ready = 1'b1;
    exp_w[0] = 16'h012C; exp_w[1] = 16'h11F4; exp_w[2] = 16'h2200;
    exp_w[3] = 16'h3064; exp_w[4] = 16'h4378; exp_w[5] = 16'h51C4;
    tick();
    chk("busy_load", {31'd0, busy}, 32'd1);
    step();
    pl1_posx = 12'd999;
    serve_frame(1'b0);

    // Two ticks during word 2 yield exactly one extra frame.
    tick();
    step();
    exp_w[0] = 16'h03E7; exp_w[5] = 16'h530F;
    serve_frame(1'b1);
    serve_frame(1'b0);
    dv0 = dv_cnt;
    repeat (30) step();
    chk("no_third_frame", dv_cnt - dv0, 32'd0);
    chk("idle_after_pending", {31'd0, busy}, 32'd0);

    // Withheld tx_done: timeout exactly TO cycles after the strobe.
    fs0 = fs_cnt;
    tick();
    wait_dv(ok);
    chk("to_dv_seen", {31'd0, ok}, 32'd1);
    chk("to_word0", {16'd0, data}, {16'd0, exp_w[0]});
    repeat (TO) step();
    chk("to_err_before", {31'd0, tx_error}, 32'd0);
    chk("to_busy_before", {31'd0, busy}, 32'd1);
    step();
    chk("to_err_set", {31'd0, tx_error}, 32'd1);
    chk("to_busy_clr", {31'd0, busy}, 32'd0);
    step();
    chk("to_no_fs", fs_cnt - fs0, 32'd0);
    tick();
    serve_frame(1'b0);
    chk("to_err_sticky", {31'd0, tx_error}, 32'd1);

    // Converter not ready for 50 cycles: strobe waits, nothing lost or doubled.
    conv16to8ready = 1'b0;
    dv0 = dv_cnt;
    tick();
    repeat (50) step();
    chk("nr_no_dv", dv_cnt - dv0, 32'd0);
    chk("nr_busy", {31'd0, busy}, 32'd1);
    conv16to8ready = 1'b1;
    serve_frame(1'b0);

    // Reset mid-frame: immediate clear, no resume, restart from tag 0.
    fs0 = fs_cnt;
    tick();
    wait_dv(ok);
    repeat (GAP - 1) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    wait_dv(ok);
    chk("rs_word1", {16'd0, data}, {16'd0, exp_w[1]});
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("rs_data", {16'd0, data}, 32'd0);
    chk("rs_busy", {31'd0, busy}, 32'd0);
    chk("rs_err", {31'd0, tx_error}, 32'd0);
    chk("rs_dv", {31'd0, data_valid}, 32'd0);
    step();
    rst = 1'b0;
    dv0 = dv_cnt;
    repeat (20) step();
    chk("rs_no_resume", dv_cnt - dv0, 32'd0);
    chk("rs_no_fs", fs_cnt - fs0, 32'd0);
    chk("rs_idle", {31'd0, busy}, 32'd0);
    tick();
    serve_frame(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
